// File: rtl/lpif_phy_ctrl_if.sv
// Link-layer <-> PHY control bundle for lpif_phy_ctrl.
// slave is the controller side, master is the link-layer/PHY side.
interface lpif_phy_ctrl_if #(
    parameter int NBYTES = 4
);
    logic [NBYTES*8-1:0] Data;
    logic                Irdy;
    logic [3:0]          state_req;
    logic                stall_ack;
    logic                ltssm_l0;
    logic                phy_tx_ready;
    logic                trdy;
    logic [3:0]          state_sts;
    logic                stall_req;
    logic                link_up;
    logic                phyinl1;
    logic                phyinrecenter;
    logic [NBYTES*8-1:0] phy_tx_data;
    logic                phy_tx_valid;

    modport master (
        output Data, Irdy, state_req, stall_ack, ltssm_l0, phy_tx_ready,
        input  trdy, state_sts, stall_req, link_up, phyinl1,
        input  phyinrecenter, phy_tx_data, phy_tx_valid
    );

    modport slave (
        input  Data, Irdy, state_req, stall_ack, ltssm_l0, phy_tx_ready,
        output trdy, state_sts, stall_req, link_up, phyinl1,
        output phyinrecenter, phy_tx_data, phy_tx_valid
    );
endinterface

// File: rtl/lpif_phy_ctrl.sv
// LPIF PHY-side state controller with TX holding FIFO.
// Define LPIF_STALL_EN to gate request-driven ACTIVE exits with a stall handshake.
module lpif_phy_ctrl #(
    parameter int NBYTES     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           PCLK,
    input  logic           reset,
    lpif_phy_ctrl_if.slave lp
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = NBYTES * 8;

`ifdef LPIF_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_RESET     = 4'b0000,
        ST_ACTIVE    = 4'b0001,
        ST_L1        = 4'b0100,
        ST_LINKRESET = 4'b1001,
        ST_RETRAIN   = 4'b1011,
        ST_DISABLED  = 4'b1100
    } lpif_state_e;

    typedef enum logic [1:0] {
        SP_IDLE,
        SP_WAIT_ACK,
        SP_WAIT_DROP
    } stall_ph_e;

    lpif_state_e st, st_n, tgt, tgt_n;
    stall_ph_e   sph, sph_n;
    logic        l1_pend, l1_pend_n;
    logic        flush;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic          empty, full, push, pop;
    logic          stall_req_i;
    logic          link_up_q, phyinl1_q, phyinrecenter_q;

    logic req_active, req_l1, req_retrain, req_kill;

    assign req_active  = (lp.state_req == ST_ACTIVE);
    assign req_l1      = (lp.state_req == ST_L1);
    assign req_retrain = (lp.state_req == ST_RETRAIN);
    assign req_kill    = (lp.state_req == ST_LINKRESET) ||
                         (lp.state_req == ST_DISABLED);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef LPIF_STALL_EN
    assign stall_req_i = (sph != SP_IDLE);
`else
    assign stall_req_i = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            st              <= ST_RESET;
            tgt             <= ST_RESET;
            sph             <= SP_IDLE;
            l1_pend         <= 1'b0;
            link_up_q       <= 1'b0;
            phyinl1_q       <= 1'b0;
            phyinrecenter_q <= 1'b0;
        end else begin
            st              <= st_n;
            tgt             <= tgt_n;
            sph             <= sph_n;
            l1_pend         <= l1_pend_n;
            link_up_q       <= (st_n == ST_ACTIVE);
            phyinl1_q       <= (st_n == ST_L1);
            phyinrecenter_q <= (st_n == ST_RETRAIN);
        end
    end

    always_comb begin
        st_n      = st;
        tgt_n     = tgt;
        sph_n     = sph;
        l1_pend_n = l1_pend;
        flush     = 1'b0;

        if (STALL_EN && sph == SP_WAIT_DROP && !lp.stall_ack)
            sph_n = SP_IDLE;

        if (req_kill) begin
            // Link reset / disable override everything, including a stall in flight
            st_n      = lpif_state_e'(lp.state_req);
            sph_n     = SP_IDLE;
            l1_pend_n = 1'b0;
            flush     = 1'b1;
        end else begin
            case (st)
                ST_RESET: begin
                    if (req_active && lp.ltssm_l0)
                        st_n = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!lp.ltssm_l0) begin
                        st_n      = ST_RETRAIN;
                        l1_pend_n = 1'b0;
                        if (sph == SP_WAIT_ACK)
                            sph_n = SP_WAIT_DROP;
                    end else if (sph == SP_WAIT_ACK) begin
                        if (lp.stall_ack) begin
                            st_n      = tgt;
                            sph_n     = SP_WAIT_DROP;
                            l1_pend_n = 1'b0;
                        end
                    end else if (sph == SP_IDLE) begin
                        if (req_retrain) begin
                            l1_pend_n = 1'b0;
                            if (STALL_EN) begin
                                sph_n = SP_WAIT_ACK;
                                tgt_n = ST_RETRAIN;
                            end else begin
                                st_n = ST_RETRAIN;
                            end
                        end else if ((req_l1 || l1_pend) && empty) begin
                            l1_pend_n = 1'b0;
                            if (STALL_EN) begin
                                sph_n = SP_WAIT_ACK;
                                tgt_n = ST_L1;
                            end else begin
                                st_n = ST_L1;
                            end
                        end else if (req_l1) begin
                            l1_pend_n = 1'b1;
                        end
                    end
                end
                ST_L1: begin
                    if (req_active)
                        st_n = ST_RETRAIN;
                end
                ST_RETRAIN: begin
                    if (lp.ltssm_l0 && !req_retrain)
                        st_n = ST_ACTIVE;
                end
                ST_LINKRESET, ST_DISABLED: begin
                    if (req_active)
                        st_n = ST_RESET;
                end
                default: st_n = ST_RESET;
            endcase
        end
    end

    // trdy looks only at registered fullness, never at a same-cycle pop
    assign lp.trdy         = (st == ST_ACTIVE) && !full && !stall_req_i;
    assign lp.phy_tx_valid = (st == ST_ACTIVE) && !empty;
    assign lp.phy_tx_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign push = lp.Irdy && lp.trdy;
    assign pop  = lp.phy_tx_valid && lp.phy_tx_ready;

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= lp.Data;
    end

    assign lp.state_sts     = st;
    assign lp.stall_req     = stall_req_i;
    assign lp.link_up       = link_up_q;
    assign lp.phyinl1       = phyinl1_q;
    assign lp.phyinrecenter = phyinrecenter_q;
endmodule

// File: tb/tb_lpif_phy_ctrl.sv
// Directed bench for lpif_phy_ctrl with a data scoreboard on the PHY side.
// Covers both builds; the stall handshake steps depend on LPIF_STALL_EN.
module tb_lpif_phy_ctrl;
    localparam logic [3:0] S_RESET = 4'b0000;
    localparam logic [3:0] S_ACT   = 4'b0001;
    localparam logic [3:0] S_L1    = 4'b0100;
    localparam logic [3:0] S_RTR   = 4'b1011;
    localparam logic [3:0] S_DIS   = 4'b1100;
    localparam logic [3:0] S_NOP   = 4'b0000;

    logic PCLK = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   npush = 0;
    bit   auto_ack = 1'b1;
    logic [31:0] sb [$];

    always #5 PCLK = ~PCLK;

    lpif_phy_ctrl_if #(.NBYTES(4)) lp ();

    lpif_phy_ctrl #(
        .NBYTES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .PCLK(PCLK),
        .reset(reset),
        .lp(lp.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples the handshakes mid-cycle, then advances past the next edge
    task automatic tick();
        logic [31:0] e;
        @(negedge PCLK);
        if (lp.Irdy && lp.trdy) begin
            sb.push_back(lp.Data);
            npush++;
        end
        if (lp.phy_tx_valid && lp.phy_tx_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_data", lp.phy_tx_data, e);
            end
        end
        @(posedge PCLK);
        #1;
        lp.Data = lp.Data + 32'd1;
        if (auto_ack)
            lp.stall_ack = lp.stall_req && (lp.state_sts == S_ACT);
    endtask

    initial begin
        int base;
        reset           = 1'b1;
        lp.Data         = 32'hA000_0000;
        lp.Irdy         = 1'b0;
        lp.state_req    = S_NOP;
        lp.stall_ack    = 1'b0;
        lp.ltssm_l0     = 1'b0;
        lp.phy_tx_ready = 1'b0;
        tick();
        tick();
        chk("rst_state", {28'd0, lp.state_sts}, {28'd0, S_RESET});
        chk("rst_trdy", {31'd0, lp.trdy}, 32'd0);
        chk("rst_stall", {31'd0, lp.stall_req}, 32'd0);
        chk("rst_valid", {31'd0, lp.phy_tx_valid}, 32'd0);
        chk("rst_data", lp.phy_tx_data, 32'd0);
        chk("rst_flags", {29'd0, lp.link_up, lp.phyinl1, lp.phyinrecenter}, 32'd0);
        reset = 1'b0;

        // Bring link up
        lp.ltssm_l0  = 1'b1;
        lp.state_req = S_ACT;
        tick();
        chk("up_state", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        chk("up_link", {31'd0, lp.link_up}, 32'd1);
        chk("up_trdy", {31'd0, lp.trdy}, 32'd1);
        lp.state_req = S_NOP;

        // Fill with PHY stalled: exactly four pushes
        base    = npush;
        lp.Irdy = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("fill_count", npush - base, 32'd4);
        chk("fill_trdy", {31'd0, lp.trdy}, 32'd0);
        chk("fill_valid", {31'd0, lp.phy_tx_valid}, 32'd1);

        // Full with ready: no push that cycle even though a pop happens
        lp.phy_tx_ready = 1'b1;
        base = npush;
        tick();
        chk("full_pop_nopush", npush - base, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        lp.Irdy = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        chk("drain_empty", sb.size(), 32'd0);
        chk("drain_valid", {31'd0, lp.phy_tx_valid}, 32'd0);

        // L1 request held until two queued words drain
        lp.phy_tx_ready = 1'b0;
        lp.Irdy = 1'b1;
        tick();
        tick();
        lp.Irdy = 1'b0;
        lp.state_req = S_L1;
        tick();
        chk("l1_pend_state", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        lp.state_req = S_NOP;
        tick();
        chk("l1_pend_state2", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        lp.phy_tx_ready = 1'b1;
        for (int i = 0; i < 12 && lp.state_sts != S_L1; i++) tick();
        chk("l1_state", {28'd0, lp.state_sts}, {28'd0, S_L1});
        chk("l1_flag", {31'd0, lp.phyinl1}, 32'd1);
        chk("l1_link", {31'd0, lp.link_up}, 32'd0);
        chk("l1_sb_empty", sb.size(), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        lp.state_req = S_ACT;
        tick();
        chk("l1_rtr", {28'd0, lp.state_sts}, {28'd0, S_RTR});
        chk("l1_rtr_flag", {31'd0, lp.phyinrecenter}, 32'd1);
        lp.state_req = S_NOP;
        tick();
        chk("rtr_act", {28'd0, lp.state_sts}, {28'd0, S_ACT});

        // Retrain request from ACTIVE
`ifdef LPIF_STALL_EN
        auto_ack     = 1'b0;
        lp.state_req = S_RTR;
        tick();
        chk("stall_req", {31'd0, lp.stall_req}, 32'd1);
        chk("stall_hold", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        chk("stall_trdy", {31'd0, lp.trdy}, 32'd0);
        tick();
        tick();
        chk("stall_hold3", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        lp.stall_ack = 1'b1;
        tick();
        chk("stall_rtr", {28'd0, lp.state_sts}, {28'd0, S_RTR});
        chk("stall_keep", {31'd0, lp.stall_req}, 32'd1);
        lp.stall_ack = 1'b0;
        lp.state_req = S_NOP;
        tick();
        chk("stall_drop", {31'd0, lp.stall_req}, 32'd0);
        auto_ack = 1'b1;
`else
        lp.state_req = S_RTR;
        lp.stall_ack = 1'b1;
        tick();
        chk("rtr_req", {28'd0, lp.state_sts}, {28'd0, S_RTR});
        chk("rtr_nostall", {31'd0, lp.stall_req}, 32'd0);
        lp.stall_ack = 1'b0;
        lp.state_req = S_NOP;
        tick();
`endif
        for (int i = 0; i < 4 && lp.state_sts != S_ACT; i++) tick();
        chk("rtr_back", {28'd0, lp.state_sts}, {28'd0, S_ACT});

        // Disable with data queued flushes the FIFO
        lp.phy_tx_ready = 1'b0;
        lp.Irdy = 1'b1;
        tick();
        tick();
        lp.Irdy = 1'b0;
        lp.state_req = S_DIS;
        tick();
        sb.delete();
        chk("dis_state", {28'd0, lp.state_sts}, {28'd0, S_DIS});
        chk("dis_valid", {31'd0, lp.phy_tx_valid}, 32'd0);
        chk("dis_data", lp.phy_tx_data, 32'd0);
        lp.state_req = S_ACT;
        tick();
        chk("dis_exit", {28'd0, lp.state_sts}, {28'd0, S_RESET});
        tick();
        chk("dis_up", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        chk("dis_flushed", {31'd0, lp.phy_tx_valid}, 32'd0);
        lp.state_req = S_NOP;

        // LTSSM drop holds queued data through RETRAIN
        lp.Irdy = 1'b1;
        tick();
        tick();
        lp.Irdy = 1'b0;
        lp.ltssm_l0 = 1'b0;
        tick();
        chk("l0_rtr", {28'd0, lp.state_sts}, {28'd0, S_RTR});
        chk("l0_nostall", {31'd0, lp.stall_req}, 32'd0);
        chk("l0_valid", {31'd0, lp.phy_tx_valid}, 32'd0);
        lp.phy_tx_ready = 1'b1;
        tick();
        chk("l0_held", sb.size(), 32'd2);
        lp.ltssm_l0 = 1'b1;
        tick();
        chk("l0_back", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
        chk("l0_drained", sb.size(), 32'd0);

        // Reset mid-transfer discards queued data
        lp.phy_tx_ready = 1'b0;
        lp.Irdy = 1'b1;
        tick();
        lp.Irdy = 1'b0;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("mrst_state", {28'd0, lp.state_sts}, {28'd0, S_RESET});
        chk("mrst_valid", {31'd0, lp.phy_tx_valid}, 32'd0);
        tick();
        reset = 1'b0;
        lp.state_req = S_ACT;
        tick();
        chk("mrst_up", {28'd0, lp.state_sts}, {28'd0, S_ACT});
        chk("mrst_empty", {31'd0, lp.phy_tx_valid}, 32'd0);
        chk("mrst_trdy", {31'd0, lp.trdy}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
